// File: rtl/sprite_loader.sv
// Sprite pixel store writer: streams row-major 12-bit pixels into an internal RAM
// and serves a registered read port. Optional SPRITE_LOADER_CHECKSUM_EN adds a 16-bit load checksum.
module sprite_loader #(
    parameter int SPRITE_WIDTH  = 17,
    parameter int SPRITE_HEIGHT = 34,
    parameter int DATA_WIDTH    = 12,
    parameter int ADDR_WIDTH    = 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] pixel_in,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    output logic                  busy,
    output logic                  done,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] load_col,
`ifdef SPRITE_LOADER_CHECKSUM_EN
    output logic [15:0]           checksum,
`endif
    output logic [ADDR_WIDTH-1:0] load_row
);
    localparam int N = SPRITE_WIDTH * SPRITE_HEIGHT;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic                  pixel_ready_q, pixel_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  xfer;

    logic [DATA_WIDTH-1:0] mem [0:N-1];

    // pixel_ready_q is high exactly while in LOAD, so it qualifies transfers.
    assign xfer = pixel_valid & pixel_ready_q;

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        col_d         = col_q;
        row_d         = row_q;
        pixel_ready_d = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = LOAD;
                    wr_addr_d     = '0;
                    col_d         = '0;
                    row_d         = '0;
                    pixel_ready_d = 1'b1;
                    busy_d        = 1'b1;
                end
            end
            LOAD: begin
                pixel_ready_d = 1'b1;
                busy_d        = 1'b1;
                if (xfer) begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (col_q == ADDR_WIDTH'(SPRITE_WIDTH - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                // abort wins over the final-pixel transition
                if (abort) begin
                    state_d       = IDLE;
                    wr_addr_d     = '0;
                    col_d         = '0;
                    row_d         = '0;
                    pixel_ready_d = 1'b0;
                    busy_d        = 1'b0;
                end else if (xfer && wr_addr_q == ADDR_WIDTH'(N - 1)) begin
                    state_d       = DONE;
                    wr_addr_d     = '0;
                    col_d         = '0;
                    row_d         = '0;
                    pixel_ready_d = 1'b0;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            wr_addr_q     <= '0;
            col_q         <= '0;
            row_q         <= '0;
            pixel_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pixel_ready_q <= pixel_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (xfer && !RST) begin
            mem[wr_addr_q] <= pixel_in;
        end
    end

    // Read-before-write: a same-cycle write to rd_addr returns the old word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data_q <= '0;
        end else if ({1'b0, rd_addr} < (ADDR_WIDTH + 1)'(N)) begin
            rd_data_q <= mem[rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == IDLE && start) begin
            checksum_d = '0;
        end else if (xfer) begin
            checksum_d = checksum_q + 16'(pixel_in);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign pixel_ready = pixel_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_data     = rd_data_q;
    assign load_col    = col_q;
    assign load_row    = row_q;
endmodule

// File: tb/tb_sprite_loader.sv
// Self-checking bench for sprite_loader: randomized loads checked against a
// transaction-level model of the sprite store (define SPRITE_LOADER_CHECKSUM_EN to cover the checksum).
module tb_sprite_loader;
    localparam int W  = 17;
    localparam int H  = 34;
    localparam int N  = W * H;
    localparam int DW = 12;
    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [DW-1:0] pixel_in;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] load_col;
    logic [AW-1:0] load_row;
`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    sprite_loader #(
        .SPRITE_WIDTH (W),
        .SPRITE_HEIGHT(H),
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .start      (start),
        .abort      (abort),
        .pixel_in   (pixel_in),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .load_col   (load_col),
`ifdef SPRITE_LOADER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .load_row   (load_row)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pixel store contents plus a transfer count for the active load.
    logic [DW-1:0] ref_mem [0:N-1];
    bit            known [0:N-1];
    bit            loading;
    bit            done_exp;
    int            count;
    int            sum_exp;
    logic [DW-1:0] rd_exp;
    bit            rd_known;
    int            load_cycles;
    int            dones_seen;
    int            errors;
    int            checks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply the spec rules to the inputs seen at the edge, then compare.
    task automatic cycle();
        bit nd;
        @(posedge clk);
        if (rst) begin
            loading  = 0;
            done_exp = 0;
            count    = 0;
            sum_exp  = 0;
            rd_exp   = '0;
            rd_known = 1;
        end else begin
            if (int'(rd_addr) < N) begin
                rd_known = known[rd_addr];
                rd_exp   = ref_mem[rd_addr];
            end else begin
                rd_known = 1;
                rd_exp   = '0;
            end
            nd = 0;
            if (loading) begin
                load_cycles++;
                if (pixel_valid) begin
                    ref_mem[count] = pixel_in;
                    known[count]   = 1;
                    sum_exp        = (sum_exp + int'(pixel_in)) % 65536;
                    count++;
                end
                if (abort) begin
                    loading = 0;
                    count   = 0;
                end else if (count == N) begin
                    loading = 0;
                    count   = 0;
                    nd      = 1;
                end
            end else if (!done_exp && start) begin
                loading = 1;
                count   = 0;
                sum_exp = 0;
            end
            done_exp = nd;
        end
        #1;
        if (done === 1'b1) dones_seen++;
        check("pixel_ready", 32'(pixel_ready), 32'(loading));
        check("busy", 32'(busy), 32'(loading));
        check("done", 32'(done), 32'(done_exp));
        check("load_col", 32'(load_col), 32'(count % W));
        check("load_row", 32'(load_row), 32'(count / W));
        if (rd_known) check("rd_data", 32'(rd_data), 32'(rd_exp));
`ifdef SPRITE_LOADER_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'(sum_exp));
`endif
    endtask

    // vmode: 0 valid always, 1 toggling, 2 random. pmode: 0 index, 1 random, 2 0xFFF.
    // ev_kind: 0 none, 1 abort idle-valid, 2 abort with transfer, 3 start, 4 reset.
    task automatic do_load(input int vmode, input int pmode, input int ev_at, input int ev_kind);
        int guard;
        bit fired;
        guard       = 0;
        fired       = 0;
        dones_seen  = 0;
        load_cycles = 0;
        start       = 1;
        pixel_valid = 0;
        rd_addr     = AW'($urandom_range(0, 639));
        cycle();
        start = 0;
        while ((loading || done_exp) && guard < 3000) begin
            case (vmode)
                0:       pixel_valid = 1;
                1:       pixel_valid = (guard % 2 == 0);
                default: pixel_valid = 1'($urandom_range(0, 1));
            endcase
            case (pmode)
                0:       pixel_in = DW'(count);
                1:       pixel_in = DW'($urandom);
                default: pixel_in = 12'hFFF;
            endcase
            if (!fired && ev_kind != 0 && loading && count == ev_at) begin
                fired = 1;
                case (ev_kind)
                    1: begin abort = 1; pixel_valid = 0; end
                    2: begin abort = 1; pixel_valid = 1; end
                    3: start = 1;
                    default: begin rst = 1; pixel_valid = 0; end
                endcase
            end
            rd_addr = AW'($urandom_range(0, 639));
            cycle();
            abort = 0;
            start = 0;
            rst   = 0;
            guard++;
        end
        pixel_valid = 0;
        check("load_timeout", 32'(guard < 3000), 32'd1);
    endtask

    task automatic sweep();
        for (int a = 0; a < N + 4; a++) begin
            rd_addr = AW'(a);
            cycle();
        end
    endtask

    initial begin
        errors = 0; checks = 0; count = 0; sum_exp = 0;
        loading = 0; done_exp = 0; rd_known = 0; rd_exp = '0;
        for (int i = 0; i < N; i++) begin
            known[i]   = 0;
            ref_mem[i] = '0;
        end
        rst = 1; start = 0; abort = 0; pixel_valid = 0; pixel_in = '0; rd_addr = '0;
        repeat (3) cycle();
        rst = 0;
        cycle();

        // Full sequential load of 0x000..0x241, valid every cycle.
        do_load(0, 0, 0, 0);
        check("full_done_pulses", 32'(dones_seen), 32'd1);
        check("full_load_cycles", 32'(load_cycles), 32'(N));
        rd_addr = AW'(0);   cycle(); cycle();
        check("rd_addr_0", 32'(rd_data), 32'h000);
        rd_addr = AW'(577); cycle(); cycle();
        check("rd_addr_577", 32'(rd_data), 32'h241);
        rd_addr = AW'(600); cycle(); cycle();
        check("rd_addr_600", 32'(rd_data), 32'h000);

        // Toggling valid: 578 transfers over 1155 LOAD cycles.
        do_load(1, 1, 0, 0);
        check("toggle_done_pulses", 32'(dones_seen), 32'd1);
        check("toggle_load_cycles", 32'(load_cycles), 32'd1155);
        sweep();

        // Abort after 100 transfers, then abort with a same-cycle transfer.
        do_load(0, 1, 100, 1);
        check("abort100_no_done", 32'(dones_seen), 32'd0);
        sweep();
        do_load(2, 1, 30, 2);
        check("abort_xfer_no_done", 32'(dones_seen), 32'd0);
        sweep();

        // start during LOAD is ignored.
        do_load(2, 1, 50, 3);
        check("start_ignored_done", 32'(dones_seen), 32'd1);

        // Reset at transfer 300, then reload from address 0.
        do_load(0, 1, 300, 4);
        check("reset_no_done", 32'(dones_seen), 32'd0);
        do_load(2, 1, 0, 0);
        check("reload_done", 32'(dones_seen), 32'd1);
        sweep();

        // Abort coinciding with the final pixel: written, but no done.
        do_load(0, 1, N - 1, 2);
        check("abort_final_no_done", 32'(dones_seen), 32'd0);
        sweep();

`ifdef SPRITE_LOADER_CHECKSUM_EN
        do_load(0, 2, 0, 0);
        check("checksum_fff", 32'(checksum), 32'h1DBE);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
